// File: rtl/vga_pixel_reader.sv
// rtl/vga_pixel_reader.sv - bus-mapped frame-buffer pixel readback responder
// Reads one pixel or eight packed pixels through a dedicated 1-bit synchronous RAM port.
module vga_pixel_reader #(
  parameter logic [7:0]  BASE_ADDR = 8'hB5,
  parameter int unsigned FB_ADDR_W = 15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_bus_addr,
  inout  wire  [7:0]           io_bus_data,
  input  logic                 i_bus_we,
  output logic [FB_ADDR_W-1:0] o_fb_addr,
  input  logic                 i_fb_data,
  output logic                 o_busy
);

  localparam logic [7:0] ADDR_X      = BASE_ADDR;
  localparam logic [7:0] ADDR_Y      = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + 8'd2;
  localparam logic [7:0] ADDR_RESULT = BASE_ADDR + 8'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]           r_x;
  logic [6:0]           r_y;
  logic [7:0]           r_result;
  logic                 r_done;
  logic [7:0]           r_base_x;
  logic [6:0]           r_base_y;
  logic                 r_pack;
  logic [2:0]           r_cnt;
  logic [7:0]           r_shift;
  logic [FB_ADDR_W-1:0] r_fb_addr;
  logic                 r_v1;
  logic                 r_v2;
  logic [2:0]           r_i1;
  logic [2:0]           r_i2;

  logic       w_wr_x;
  logic       w_wr_y;
  logic       w_wr_ctrl;
  logic       w_rd_sel;
  logic       w_rd_result;
  logic       w_start;
  logic       w_busy;
  logic       w_issue;
  logic       w_complete;
  logic [2:0] w_issue_idx;
  logic [2:0] w_last_idx;
  logic [7:0] w_issue_x;
  logic [6:0] w_issue_y;
  logic [7:0] w_shift_cap;
  logic [7:0] w_rd_data;

  assign w_busy      = (r_state != S_IDLE);
  assign w_wr_x      = i_bus_we && (i_bus_addr == ADDR_X);
  assign w_wr_y      = i_bus_we && (i_bus_addr == ADDR_Y);
  assign w_wr_ctrl   = i_bus_we && (i_bus_addr == ADDR_CTRL);
  assign w_rd_result = !i_bus_we && (i_bus_addr == ADDR_RESULT);
  assign w_rd_sel    = !i_bus_we && ((i_bus_addr == ADDR_X) || (i_bus_addr == ADDR_Y) ||
                                     (i_bus_addr == ADDR_CTRL) || (i_bus_addr == ADDR_RESULT));
  assign w_start     = w_wr_ctrl && !w_busy;
  assign w_last_idx  = r_pack ? 3'd7 : 3'd0;

  // Pixel 0 is issued on the start edge itself, straight from the live X/Y registers.
  assign w_issue_x = (r_state == S_IDLE) ? r_x : (r_base_x + {5'd0, r_cnt});
  assign w_issue_y = (r_state == S_IDLE) ? r_y : r_base_y;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_issue_idx  = r_cnt;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_issue      = 1'b1;
          w_issue_idx  = 3'd0;
          w_state_next = io_bus_data[0] ? S_FETCH : S_DRAIN;
        end
      end
      S_FETCH: begin
        w_issue = 1'b1;
        if (r_cnt == 3'd7) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_v2 && (r_i2 == w_last_idx)) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shift_cap       = r_shift;
    w_shift_cap[r_i2] = i_fb_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x       <= 8'd0;
      r_y       <= 7'd0;
      r_result  <= 8'd0;
      r_done    <= 1'b0;
      r_base_x  <= 8'd0;
      r_base_y  <= 7'd0;
      r_pack    <= 1'b0;
      r_cnt     <= 3'd0;
      r_shift   <= 8'd0;
      r_fb_addr <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_i1      <= 3'd0;
      r_i2      <= 3'd0;
    end else begin
      if (w_wr_x) begin
        r_x <= io_bus_data;
      end
      if (w_wr_y) begin
        r_y <= io_bus_data[6:0];
      end
      if (w_start) begin
        r_base_x <= r_x;
        r_base_y <= r_y;
        r_pack   <= io_bus_data[0];
        r_cnt    <= 3'd1;
        r_shift  <= 8'd0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_issue) begin
        r_fb_addr <= FB_ADDR_W'({w_issue_y, w_issue_x});
      end
      // Two-stage index pipe: address out, RAM read, then capture.
      r_v1 <= w_issue;
      r_i1 <= w_issue_idx;
      r_v2 <= r_v1;
      r_i2 <= r_i1;
      if (r_v2) begin
        r_shift[r_i2] <= i_fb_data;
      end
      if (w_complete) begin
        r_result <= w_shift_cap;
        r_done   <= 1'b1;
      end else if (w_start || w_rd_result) begin
        r_done <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (i_bus_addr)
      ADDR_X:      w_rd_data = r_x;
      ADDR_Y:      w_rd_data = {1'b0, r_y};
      ADDR_CTRL:   w_rd_data = {6'b0, r_done, w_busy};
      ADDR_RESULT: w_rd_data = r_result;
      default:     w_rd_data = 8'h00;
    endcase
  end

  assign io_bus_data = w_rd_sel ? w_rd_data : 8'hzz;
  assign o_fb_addr   = r_fb_addr;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_vga_pixel_reader.sv
// tb/tb_vga_pixel_reader.sv - self-checking bench for vga_pixel_reader
// Transaction-level model of registers and read timing plus directed literal checks.
module tb_vga_pixel_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bus_addr;
  logic        bus_we;
  logic        bus_oe;
  logic [7:0]  bus_drv;
  wire  [7:0]  bus_data;
  logic [14:0] fb_addr;
  logic        fb_data = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  assign bus_data = bus_oe ? bus_drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup u_pu (bus_data[g]);
  end

  vga_pixel_reader #(.BASE_ADDR(8'hB5), .FB_ADDR_W(15)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_bus_addr (bus_addr),
    .io_bus_data(bus_data),
    .i_bus_we   (bus_we),
    .o_fb_addr  (fb_addr),
    .i_fb_data  (fb_data),
    .o_busy     (busy)
  );

  bit fb_mem [0:32767];
  always @(posedge clk) fb_data <= fb_mem[fb_addr];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation takes n issues + 1 cycles; its result is known at start.
  logic [7:0]  m_x = 8'd0;
  logic [6:0]  m_y = 7'd0;
  logic [7:0]  m_result = 8'd0;
  logic [7:0]  m_pend = 8'd0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [14:0] m_fb_addr = 15'd0;
  logic [14:0] m_addrs [$];
  bit          md_rd, md_st, md_cpl;
  int          md_n;
  logic [7:0]  md_xi;

  always @(posedge clk) begin
    if (rst) begin
      m_x = 8'd0; m_y = 7'd0; m_result = 8'd0; m_done = 1'b0;
      m_left = 0; m_fb_addr = 15'd0; m_addrs.delete();
    end else begin
      md_rd  = !bus_we && (bus_addr == 8'hB8);
      md_st  = bus_we && (bus_addr == 8'hB7) && (m_left == 0);
      md_cpl = 1'b0;
      if (m_addrs.size() > 0) m_fb_addr = m_addrs.pop_front();
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          md_cpl   = 1'b1;
          m_result = m_pend;
        end
      end
      if (md_cpl) m_done = 1'b1;
      else if (md_st || md_rd) m_done = 1'b0;
      if (md_st) begin
        md_n   = bus_drv[0] ? 8 : 1;
        m_left = md_n + 1;
        m_pend = 8'd0;
        for (int i = 0; i < md_n; i++) begin
          md_xi = m_x + 8'(i);
          m_pend[i] = fb_mem[{m_y, md_xi}];
          if (i == 0) m_fb_addr = {m_y, md_xi};
          else m_addrs.push_back({m_y, md_xi});
        end
      end
      if (bus_we && bus_addr == 8'hB5) m_x = bus_drv;
      if (bus_we && bus_addr == 8'hB6) m_y = bus_drv[6:0];
    end
  end

  function automatic logic [7:0] exp_bus(input logic [7:0] a, input logic we);
    if (we) return 8'hFF;
    case (a)
      8'hB5:   return m_x;
      8'hB6:   return {1'b0, m_y};
      8'hB7:   return {6'b0, m_done, (m_left != 0)};
      8'hB8:   return m_result;
      default: return 8'hFF;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 16'(busy), 16'(m_left != 0));
      chk("fb_addr", 16'(fb_addr), 16'(m_fb_addr));
      if (!bus_oe) chk("bus", 16'(bus_data), 16'(exp_bus(bus_addr, bus_we)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_we = 1'b0; bus_addr = 8'h00; bus_oe = 1'b0; bus_drv = 8'h00;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_we = 1'b1; bus_addr = a; bus_oe = 1'b1; bus_drv = d;
    tick();
    idle();
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus_we = 1'b0; bus_addr = a; bus_oe = 1'b0;
    #1;
    chk(name, 16'(bus_data), 16'(exp));
    tick();
    idle();
  endtask

  logic [14:0] wrap_exp [8];

  initial begin
    wrap_exp = '{15'h00FE, 15'h00FF, 15'h0000, 15'h0001,
                 15'h0002, 15'h0003, 15'h0004, 15'h0005};
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_fb_addr", 16'(fb_addr), 16'd0);
    rd_chk("rst_status", 8'hB7, 8'h00);
    rd_chk("rst_result", 8'hB8, 8'h00);

    // single read
    fb_mem[{7'd10, 8'd20}] = 1'b1;
    wr(8'hB5, 8'd20);
    wr(8'hB6, 8'd10);
    wr(8'hB7, 8'h00);
    chk("t1_addr", 16'(fb_addr), 16'h0A14);
    chk("t1_busy_e0", 16'(busy), 16'd1);
    tick();
    chk("t1_busy_e1", 16'(busy), 16'd1);
    tick();
    chk("t1_busy_e2", 16'(busy), 16'd0);
    rd_chk("t1_status", 8'hB7, 8'h02);
    rd_chk("t1_result", 8'hB8, 8'h01);
    rd_chk("t1_status_clr", 8'hB7, 8'h00);
    fb_mem[{7'd10, 8'd20}] = 1'b0;
    wr(8'hB7, 8'h00);
    tick();
    tick();
    rd_chk("t1_result_zero", 8'hB8, 8'h00);

    // pack8
    {fb_mem[15'h0328], fb_mem[15'h0329], fb_mem[15'h032A], fb_mem[15'h032B]} = 4'b1011;
    {fb_mem[15'h032C], fb_mem[15'h032D], fb_mem[15'h032E], fb_mem[15'h032F]} = 4'b0001;
    wr(8'hB5, 8'd40);
    wr(8'hB6, 8'd3);
    wr(8'hB7, 8'h01);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("t2_addr", 16'(fb_addr), 16'h0328 + 16'(k));
    end
    tick();
    chk("t2_busy_e8", 16'(busy), 16'd1);
    tick();
    chk("t2_busy_e9", 16'(busy), 16'd0);
    chk("t2_model", 16'(m_result), 16'h008D);
    rd_chk("t2_status", 8'hB7, 8'h02);
    rd_chk("t2_result", 8'hB8, 8'h8D);

    // X wrap, with a RESULT read landing on the completion edge
    fb_mem[{7'd0, 8'd254}] = 1'b1;
    fb_mem[{7'd0, 8'd1}]   = 1'b1;
    wr(8'hB5, 8'd254);
    wr(8'hB6, 8'd0);
    wr(8'hB7, 8'h01);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("t3_addr", 16'(fb_addr), 16'(wrap_exp[k]));
    end
    tick();
    bus_we = 1'b0; bus_addr = 8'hB8; bus_oe = 1'b0;
    tick();
    idle();
    chk("t3_busy_e9", 16'(busy), 16'd0);
    rd_chk("t3_status_done_wins", 8'hB7, 8'h02);
    rd_chk("t3_result", 8'hB8, 8'h09);
    rd_chk("t3_status_clr", 8'hB7, 8'h00);

    // start while busy, and start on the edge BUSY falls
    wr(8'hB5, 8'd40);
    wr(8'hB6, 8'd3);
    wr(8'hB7, 8'h01);
    tick();
    tick();
    wr(8'hB7, 8'h00);
    wr(8'hB5, 8'd99);
    repeat (4) tick();
    chk("t4_busy_e8", 16'(busy), 16'd1);
    wr(8'hB7, 8'h00);
    chk("t4_busy_e9", 16'(busy), 16'd0);
    tick();
    chk("t4_no_restart", 16'(busy), 16'd0);
    rd_chk("t4_result", 8'hB8, 8'h8D);
    rd_chk("t4_x", 8'hB5, 8'd99);

    // reset in the middle of a pack8
    wr(8'hB5, 8'd40);
    wr(8'hB7, 8'h01);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 16'(busy), 16'd0);
    chk("t5_fb_addr", 16'(fb_addr), 16'd0);
    rd_chk("t5_status", 8'hB7, 8'h00);
    rd_chk("t5_result", 8'hB8, 8'h00);
    rd_chk("t5_x", 8'hB5, 8'h00);
    repeat (10) tick();
    chk("t5_no_completion", 16'(busy), 16'd0);
    rd_chk("t5_status_late", 8'hB7, 8'h00);

    // DONE clear and bus release
    wr(8'hB5, 8'd1);
    wr(8'hB7, 8'h00);
    tick();
    tick();
    rd_chk("t6_status", 8'hB7, 8'h02);
    rd_chk("t6_result", 8'hB8, 8'h01);
    rd_chk("t6_status_clr", 8'hB7, 8'h00);
    bus_we = 1'b0; bus_addr = 8'hB0; bus_oe = 1'b0;
    #1;
    chk("t6_float_addr", 16'(bus_data), 16'h00FF);
    bus_we = 1'b1; bus_addr = 8'hB8;
    #1;
    chk("t6_float_we", 16'(bus_data), 16'h00FF);
    tick();
    idle();
    rd_chk("t6_result_kept", 8'hB8, 8'h01);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
